// File: rtl/bram_mem_port_pkg.sv
// bram_mem_port_pkg: FSM encoding, byte-count derivation and mask helpers shared by bram_mem_port.
package bram_mem_port_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RMW_MERGE = 2'd2
  } state_e;
  localparam int MAX_BYTES = 64;
  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction
  // Lanes at or above n are forced high so only the live lanes decide.
  function automatic logic mask_full(input logic [MAX_BYTES-1:0] mask, input int n);
    return &(mask | ({MAX_BYTES{1'b1}} << n));
  endfunction
endpackage

// File: rtl/bram_mem_port_if.sv
// bram_mem_port_if: request/response handshake between the memory stage (master) and bram_mem_port (slave).
interface bram_mem_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_byte_en;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_is_store;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byte_en, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_is_store
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byte_en, resp_ready,
    output req_ready, resp_valid, resp_data, resp_is_store
  );
endinterface

// File: rtl/bram_byte_merge.sv
// bram_byte_merge: per-byte mux taking masked bytes from the new word and the rest from the old word.
module bram_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] mask_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);
  for (genvar g = 0; g < DATA_WIDTH / 8; g++) begin : g_lane
    assign merged_o[8*g +: 8] = mask_i[g] ? new_i[8*g +: 8] : old_i[8*g +: 8];
  end
endmodule

// File: rtl/bram_mem_port.sv
// bram_mem_port: load/store front end for a byte-enable-less BRAM, with read-modify-write for partial stores.
// Define BRAM_MEM_PORT_STORE_ACK_EN to return a store acknowledge (resp_is_store=1, data 0) for every store.
module bram_mem_port
  import bram_mem_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  bram_mem_port_if.slave        bus,
  output logic                  mem_read_enable_o,
  output logic [ADDR_WIDTH-1:0] mem_read_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  output logic                  mem_write_enable_o,
  output logic [ADDR_WIDTH-1:0] mem_write_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o
);
  localparam int BYTES = bytes_of(DATA_WIDTH);
  state_e                state_q, state_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_is_store_q, resp_is_store_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      be_q, be_d;
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept, is_load, is_full, is_zero, is_part, ack;
  assign bus.req_ready = state_q == IDLE && (!resp_valid_q || bus.resp_ready);
  assign accept  = bus.req_valid && bus.req_ready;
  assign is_load = accept && !bus.req_write;
  assign is_full = accept && bus.req_write && mask_full(MAX_BYTES'(bus.req_byte_en), BYTES);
  assign is_zero = accept && bus.req_write && bus.req_byte_en == '0;
  assign is_part = accept && bus.req_write && !is_full && !is_zero;
`ifdef BRAM_MEM_PORT_STORE_ACK_EN
  // The ack lands the cycle after the RAM write (or after accept for an empty mask).
  assign ack = is_full || is_zero || state_q == RMW_MERGE;
`else
  assign ack = 1'b0;
`endif
  bram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i    (mem_read_data_i),
    .new_i    (wdata_q),
    .mask_i   (be_q),
    .merged_o (merged)
  );
  always_ff @(posedge clock_i) state_q <= !reset_ni ? IDLE : state_d;
  always_comb begin
    state_d = state_q != IDLE ? IDLE : is_load ? RD_WAIT : is_part ? RMW_MERGE : IDLE;
  end
  // Strobes are gated by reset so an abandoned RMW never reaches the RAM.
  always_comb begin
    mem_read_enable_o  = reset_ni && (is_load || is_part);
    mem_read_addr_o    = bus.req_addr;
    mem_write_enable_o = reset_ni && (is_full || state_q == RMW_MERGE);
    mem_write_addr_o   = state_q == RMW_MERGE ? addr_q : bus.req_addr;
    mem_write_data_o   = state_q == RMW_MERGE ? merged : bus.req_wdata;
  end
  always_comb begin
    resp_valid_d    = state_q == RD_WAIT || ack || (resp_valid_q && !bus.resp_ready);
    resp_data_d     = state_q == RD_WAIT ? mem_read_data_i : ack ? '0 : resp_data_q;
    resp_is_store_d = state_q == RD_WAIT ? 1'b0 : ack ? 1'b1 : resp_is_store_q;
    addr_d          = accept ? bus.req_addr : addr_q;
    wdata_d         = accept ? bus.req_wdata : wdata_q;
    be_d            = accept ? bus.req_byte_en : be_q;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      resp_valid_q    <= 1'b0;
      resp_is_store_q <= 1'b0;
      resp_data_q     <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
    end else begin
      resp_valid_q    <= resp_valid_d;
      resp_is_store_q <= resp_is_store_d;
      resp_data_q     <= resp_data_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      be_q            <= be_d;
    end
  end
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_is_store = resp_is_store_q;
endmodule

// File: tb/tb_bram_mem_port.sv
// tb_bram_mem_port: random and directed traffic against a transaction-level memory model of bram_mem_port.
module tb_bram_mem_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  logic        mem_re, mem_we;
  logic [7:0]  mem_ra, mem_wa;
  logic [31:0] mem_rd, mem_wd;
  logic [31:0] ram [256];
  logic [31:0] gold [256];
  int          nvec = 0, nerr = 0;
  logic [31:0] last_resp = '0;
  typedef struct {logic [31:0] d; logic st; int due;} resp_t;
  typedef struct {logic [7:0] a; logic [31:0] d; int due;} wchk_t;
  resp_t rq[$];
  wchk_t rchk[$];
  bram_mem_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
  bram_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock_i            (clk),
    .reset_ni           (rst_n),
    .bus                (bus),
    .mem_read_enable_o  (mem_re),
    .mem_read_addr_o    (mem_ra),
    .mem_read_data_i    (mem_rd),
    .mem_write_enable_o (mem_we),
    .mem_write_addr_o   (mem_wa),
    .mem_write_data_o   (mem_wd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] init_word(input int i);
    return i == 5 ? 32'hDEADBEEF : i == 32 ? 32'h11223344 : i == 48 ? 32'hCAFEF00D
         : 32'h9E3779B9 * 32'(i + 1);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] m = o;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = n[8*i +: 8];
    return m;
  endfunction
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_we) ram[mem_wa] <= mem_wd;
      if (mem_re) mem_rd <= ram[mem_ra];
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Model: memory updates at the cycle the write is due, responses carry the cycle they must appear.
  initial begin
    logic exp_rv, exp_rdy, acc, full, zero, wr_now, exp_re, exp_we, wfull;
    logic [3:0] be;
    logic [7:0] pend_a = '0;
    logic [31:0] pend_d = '0;
    logic pend_v = 1'b0;
    int pend_c = 0, busy = 0;
    for (int i = 0; i < 256; i++) gold[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_read_en", 32'(mem_re), 32'd0);
        chk("rst_write_en", 32'(mem_we), 32'd0);
        rq.delete();
        rchk.delete();
        pend_v = 1'b0;
        busy = 0;
      end else begin
        exp_rv = rq.size() > 0 && cyc >= rq[0].due;
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        if (exp_rv) begin
          chk("resp_data", bus.resp_data, rq[0].d);
          chk("resp_is_store", 32'(bus.resp_is_store), 32'(rq[0].st));
        end
        exp_rdy = cyc >= busy && (!exp_rv || bus.resp_ready);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        acc = bus.req_valid && exp_rdy;
        be = bus.req_byte_en;
        full = be == 4'hF;
        zero = be == 4'h0;
        wr_now = pend_v && pend_c == cyc;
        wfull = acc && bus.req_write && full;
        exp_re = acc && (!bus.req_write || (!full && !zero));
        exp_we = wfull || wr_now;
        chk("read_en", 32'(mem_re), 32'(exp_re));
        chk("write_en", 32'(mem_we), 32'(exp_we));
        if (exp_re) chk("read_addr", 32'(mem_ra), 32'(bus.req_addr));
        if (wfull) begin
          chk("write_addr", 32'(mem_wa), 32'(bus.req_addr));
          chk("write_data", mem_wd, bus.req_wdata);
          gold[bus.req_addr] = bus.req_wdata;
          rchk.push_back('{bus.req_addr, bus.req_wdata, cyc + 1});
        end
        if (wr_now) begin
          chk("rmw_addr", 32'(mem_wa), 32'(pend_a));
          chk("rmw_data", mem_wd, pend_d);
          gold[pend_a] = pend_d;
          rchk.push_back('{pend_a, pend_d, cyc + 1});
          pend_v = 1'b0;
        end
        if (exp_rv && bus.resp_ready) begin
          last_resp = bus.resp_data;
          void'(rq.pop_front());
        end
        while (rchk.size() > 0 && rchk[0].due <= cyc) begin
          chk("ram_word", ram[rchk[0].a], rchk[0].d);
          void'(rchk.pop_front());
        end
        if (acc && !bus.req_write) begin
          rq.push_back('{gold[bus.req_addr], 1'b0, cyc + 2});
          busy = cyc + 2;
        end else if (acc && (full || zero)) begin
          busy = cyc + 1;
`ifdef BRAM_MEM_PORT_STORE_ACK_EN
          rq.push_back('{32'd0, 1'b1, cyc + 1});
`endif
        end else if (acc) begin
          pend_v = 1'b1;
          pend_a = bus.req_addr;
          pend_d = merge(gold[bus.req_addr], bus.req_wdata, be);
          pend_c = cyc + 1;
          busy = cyc + 2;
`ifdef BRAM_MEM_PORT_STORE_ACK_EN
          rq.push_back('{32'd0, 1'b1, cyc + 2});
`endif
        end
      end
    end
  end
  task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bit done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_byte_en = be;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = bus.req_ready;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      nvec++;
      nerr++;
      $display("FAIL req_timeout: got no accept, expected accept within 20 cycles (addr %h)", a);
    end
  endtask
  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int r;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_byte_en = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_is_store", 32'(bus.resp_is_store), 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 8'h05, 32'd0, 4'h0);
    idle(3);
    chk("load_05", last_resp, 32'hDEADBEEF);
    do_req(1'b1, 8'h10, 32'h12345678, 4'hF);
    do_req(1'b0, 8'h10, 32'd0, 4'h0);
    idle(3);
    chk("load_10", last_resp, 32'h12345678);
    do_req(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101);
    idle(2);
    chk("rmw_ram_20", ram[8'h20], 32'h11BB33DD);
    chk("rmw_gold_20", gold[8'h20], 32'h11BB33DD);
    bus.resp_ready = 1'b0;
    do_req(1'b0, 8'h20, 32'd0, 4'h0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr = 8'h05;
    repeat (6) @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    idle(3);
    chk("bp_load_05", last_resp, 32'hDEADBEEF);
    do_req(1'b1, 8'h30, 32'h01020304, 4'b0011);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 8'h30, 32'd0, 4'h0);
    idle(3);
    chk("mid_rst_word", last_resp, 32'hCAFEF00D);
    chk("mid_rst_gold", gold[8'h30], 32'hCAFEF00D);
`ifdef BRAM_MEM_PORT_STORE_ACK_EN
    do_req(1'b1, 8'h40, 32'h55AA55AA, 4'hF);
    @(negedge clk);
    chk("ack_full_valid", 32'(bus.resp_valid), 32'd1);
    chk("ack_full_is_store", 32'(bus.resp_is_store), 32'd1);
    chk("ack_full_data", bus.resp_data, 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b1, 8'h41, 32'h77777777, 4'h0);
    @(negedge clk);
    chk("ack_zero_valid", 32'(bus.resp_valid), 32'd1);
    chk("ack_zero_is_store", 32'(bus.resp_is_store), 32'd1);
    chk("ack_zero_no_write", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
`endif
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 7);
      bus.req_valid = $urandom_range(0, 9) < 7;
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr = 8'($urandom_range(0, 15));
      bus.req_wdata = $urandom;
      bus.req_byte_en = r == 0 ? 4'h0 : r < 3 ? 4'hF : 4'($urandom);
      bus.resp_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 299) != 0;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    idle(6);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of run, expected finish before 400000 time units");
    $fatal(1);
  end
endmodule
